// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: captures the live time, edits hour/min/sec, then loads all three at once.
// Latency: outputs are registered from the current state, so they show a state one cycle after it is entered.
// Backpressure: none; button pulses are single-cycle and always consumed.
module time_set_ctrl #(
    parameter int TIMEOUT   = 30000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       run_en,
    output logic       hour_load,
    output logic [4:0] hour_data,
    output logic       min_load,
    output logic [5:0] min_data,
    output logic       sec_load,
    output logic [5:0] sec_data,
    output logic [1:0] edit_field,
    output logic       blink
);

    typedef enum logic [2:0] {
        S_RUN,
        S_EDIT_HOUR,
        S_EDIT_MIN,
        S_EDIT_SEC,
        S_COMMIT
    } state_t;

    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

    state_t      state_q, state_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_tog_q, blink_tog_d;

    logic        run_en_q, run_en_d;
    logic        load_q, load_d;
    logic [4:0]  hour_data_q, hour_data_d;
    logic [5:0]  min_data_q, min_data_d;
    logic [5:0]  sec_data_q, sec_data_d;
    logic [1:0]  edit_field_q, edit_field_d;
    logic        blink_q, blink_d;

    logic        in_edit;
    logic        next_edit;
    logic        tmo_expired;

    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        tmo_cnt_d   = '0;
        blink_cnt_d = '0;
        blink_tog_d = 1'b0;

        in_edit     = (state_q == S_EDIT_HOUR) || (state_q == S_EDIT_MIN) ||
                      (state_q == S_EDIT_SEC);
        tmo_expired = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

        // Button pulses take priority over expiry; mode beats inc.
        case (state_q)
            S_RUN: begin
                if (btn_mode) begin
                    hour_d  = cur_hour;
                    min_d   = cur_min;
                    sec_d   = cur_sec;
                    state_d = S_EDIT_HOUR;
                end
            end
            S_EDIT_HOUR: begin
                if (btn_mode)       state_d = S_EDIT_MIN;
                else if (btn_inc)   hour_d  = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
                else if (tmo_expired) state_d = S_RUN;
            end
            S_EDIT_MIN: begin
                if (btn_mode)       state_d = S_EDIT_SEC;
                else if (btn_inc)   min_d   = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
                else if (tmo_expired) state_d = S_RUN;
            end
            S_EDIT_SEC: begin
                if (btn_mode)       state_d = S_COMMIT;
                else if (btn_inc)   sec_d   = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
                else if (tmo_expired) state_d = S_RUN;
            end
            S_COMMIT: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase

        if (in_edit && !btn_mode && !btn_inc && (state_d == state_q))
            tmo_cnt_d = tmo_cnt_q + 32'd1;

        // Blink phase runs across field changes and restarts only from RUN.
        next_edit = (state_d == S_EDIT_HOUR) || (state_d == S_EDIT_MIN) ||
                    (state_d == S_EDIT_SEC);
        if (in_edit && next_edit) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_tog_d = ~blink_tog_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
                blink_tog_d = blink_tog_q;
            end
        end

        run_en_d     = (state_q == S_RUN);
        load_d       = (state_q == S_COMMIT);
        blink_d      = in_edit && blink_tog_q;
        hour_data_d  = hour_data_q;
        min_data_d   = min_data_q;
        sec_data_d   = sec_data_q;
        if (state_q != S_RUN) begin
            hour_data_d = hour_q;
            min_data_d  = min_q;
            sec_data_d  = sec_q;
        end
        case (state_q)
            S_EDIT_HOUR: edit_field_d = 2'd1;
            S_EDIT_MIN:  edit_field_d = 2'd2;
            S_EDIT_SEC:  edit_field_d = 2'd3;
            default:     edit_field_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q      <= S_RUN;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            tmo_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            blink_tog_q  <= 1'b0;
            run_en_q     <= 1'b1;
            load_q       <= 1'b0;
            hour_data_q  <= '0;
            min_data_q   <= '0;
            sec_data_q   <= '0;
            edit_field_q <= '0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            tmo_cnt_q    <= tmo_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_tog_q  <= blink_tog_d;
            run_en_q     <= run_en_d;
            load_q       <= load_d;
            hour_data_q  <= hour_data_d;
            min_data_q   <= min_data_d;
            sec_data_q   <= sec_data_d;
            edit_field_q <= edit_field_d;
            blink_q      <= blink_d;
        end
    end

    assign run_en     = run_en_q;
    assign hour_load  = load_q;
    assign min_load   = load_q;
    assign sec_load   = load_q;
    assign hour_data  = hour_data_q;
    assign min_data   = min_data_q;
    assign sec_data   = sec_data_q;
    assign edit_field = edit_field_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a short timeout and blink period.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       run_en, hour_load, min_load, sec_load, blink;
    logic [4:0] hour_data;
    logic [5:0] min_data, sec_data;
    logic [1:0] edit_field;

    int n_tests = 0;
    int n_fail  = 0;
    int load_seen = 0;

    time_set_ctrl #(.TIMEOUT(16), .BLINK_DIV(4)) dut (
        .clk(clk), .clear(clear), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .hour_load(hour_load), .hour_data(hour_data),
        .min_load(min_load), .min_data(min_data), .sec_load(sec_load),
        .sec_data(sec_data), .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hour_load || min_load || sec_load) load_seen++;

    // All tasks start and end just after a falling edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; @(negedge clk); btn_mode = 1'b0;
    endtask

    task automatic pulse_inc();
        btn_inc = 1'b1; @(negedge clk); btn_inc = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        wait_cyc(2);
        n_tests++; if (run_en !== 1'b1) begin n_fail++; $display("FAIL reset_run_en: got %b want 1", run_en); end
        n_tests++; if ({hour_load, min_load, sec_load} !== 3'b000) begin n_fail++; $display("FAIL reset_loads: got %b want 000", {hour_load, min_load, sec_load}); end
        n_tests++; if ({hour_data, min_data, sec_data} !== 17'd0) begin n_fail++; $display("FAIL reset_data: got %0d/%0d/%0d want 0/0/0", hour_data, min_data, sec_data); end
        n_tests++; if (edit_field !== 2'd0 || blink !== 1'b0) begin n_fail++; $display("FAIL reset_field_blink: got %0d/%b want 0/0", edit_field, blink); end
        clear = 1'b1;
        wait_cyc(1);
        pulse_inc();
        wait_cyc(2);
        n_tests++; if (edit_field !== 2'd0 || run_en !== 1'b1) begin n_fail++; $display("FAIL run_inc_ignored: field %0d run_en %b want 0/1", edit_field, run_en); end
    endtask

    task automatic test_full_set();
        int base;
        base = load_seen;
        cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
        pulse_mode();
        wait_cyc(1);
        n_tests++; if (run_en !== 1'b0 || edit_field !== 2'd1) begin n_fail++; $display("FAIL enter_edit: run_en %b field %0d want 0/1", run_en, edit_field); end
        n_tests++; if (hour_data !== 5'd10) begin n_fail++; $display("FAIL capture_hour: got %0d want 10", hour_data); end
        repeat (3) pulse_inc();
        wait_cyc(1);
        n_tests++; if (hour_data !== 5'd13) begin n_fail++; $display("FAIL hour_inc3: got %0d want 13", hour_data); end
        pulse_mode();
        repeat (2) pulse_inc();
        pulse_mode();
        pulse_inc();
        wait_cyc(1);
        n_tests++; if (edit_field !== 2'd3 || min_data !== 6'd22 || sec_data !== 6'd31) begin n_fail++; $display("FAIL sec_field: field %0d min %0d sec %0d want 3/22/31", edit_field, min_data, sec_data); end
        pulse_mode();
        n_tests++; if (hour_load !== 1'b0) begin n_fail++; $display("FAIL commit_early: load %b want 0", hour_load); end
        wait_cyc(1);
        n_tests++; if ({hour_load, min_load, sec_load} !== 3'b111 || run_en !== 1'b0 || edit_field !== 2'd0) begin n_fail++; $display("FAIL commit_strobe: loads %b run_en %b field %0d want 111/0/0", {hour_load, min_load, sec_load}, run_en, edit_field); end
        n_tests++; if (hour_data !== 5'd13 || min_data !== 6'd22 || sec_data !== 6'd31) begin n_fail++; $display("FAIL commit_data: got %0d/%0d/%0d want 13/22/31", hour_data, min_data, sec_data); end
        wait_cyc(1);
        n_tests++; if (run_en !== 1'b1 || hour_load !== 1'b0) begin n_fail++; $display("FAIL after_commit: run_en %b load %b want 1/0", run_en, hour_load); end
        wait_cyc(3);
        n_tests++; if (load_seen - base !== 1) begin n_fail++; $display("FAIL load_count: got %0d want 1", load_seen - base); end
        n_tests++; if (hour_data !== 5'd13 || blink !== 1'b0) begin n_fail++; $display("FAIL run_hold: hour %0d blink %b want 13/0", hour_data, blink); end
    endtask

    task automatic test_wrap();
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd59;
        pulse_mode();
        pulse_inc();
        pulse_mode();
        pulse_inc();
        wait_cyc(1);
        n_tests++; if (edit_field !== 2'd2 || hour_data !== 5'd0 || min_data !== 6'd0) begin n_fail++; $display("FAIL min_wrap: field %0d hour %0d min %0d want 2/0/0", edit_field, hour_data, min_data); end
        pulse_mode();
        pulse_inc();
        pulse_mode();
        wait_cyc(1);
        n_tests++; if (hour_load !== 1'b1 || {hour_data, min_data, sec_data} !== 17'd0) begin n_fail++; $display("FAIL wrap_commit: load %b data %0d/%0d/%0d want 1 0/0/0", hour_load, hour_data, min_data, sec_data); end
        wait_cyc(2);
    endtask

    task automatic test_out_of_range();
        cur_hour = 5'd31; cur_min = 6'd63; cur_sec = 6'd60;
        pulse_mode();
        pulse_inc();
        pulse_mode();
        pulse_mode();
        pulse_inc();
        pulse_inc();
        pulse_mode();
        wait_cyc(1);
        n_tests++; if (hour_load !== 1'b1 || hour_data !== 5'd0 || min_data !== 6'd63 || sec_data !== 6'd1) begin n_fail++; $display("FAIL out_of_range: load %b data %0d/%0d/%0d want 1 0/63/1", hour_load, hour_data, min_data, sec_data); end
        wait_cyc(2);
    endtask

    task automatic test_simultaneous();
        cur_hour = 5'd5; cur_min = 6'd7; cur_sec = 6'd9;
        pulse_mode();
        btn_mode = 1'b1; btn_inc = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0;
        wait_cyc(1);
        n_tests++; if (edit_field !== 2'd2 || hour_data !== 5'd5) begin n_fail++; $display("FAIL mode_wins: field %0d hour %0d want 2/5", edit_field, hour_data); end
        pulse_mode();
        pulse_mode();
        wait_cyc(3);
    endtask

    task automatic test_timeout();
        int base;
        logic exp_blink;
        base = load_seen;
        cur_hour = 5'd4; cur_min = 6'd5; cur_sec = 6'd6;
        pulse_mode();
        for (int k = 1; k <= 17; k++) begin
            wait_cyc(1);
            exp_blink = (k <= 16) && (((k - 1) / 4) % 2 == 1);
            n_tests++; if (blink !== exp_blink) begin n_fail++; $display("FAIL blink_k%0d: got %b want %b", k, blink, exp_blink); end
            if (k == 16) begin
                n_tests++; if (run_en !== 1'b0 || edit_field !== 2'd1) begin n_fail++; $display("FAIL before_abort: run_en %b field %0d want 0/1", run_en, edit_field); end
            end
        end
        n_tests++; if (run_en !== 1'b1 || edit_field !== 2'd0) begin n_fail++; $display("FAIL abort: run_en %b field %0d want 1/0", run_en, edit_field); end
        wait_cyc(2);
        n_tests++; if (load_seen !== base) begin n_fail++; $display("FAIL abort_no_load: got %0d loads want 0", load_seen - base); end
    endtask

    task automatic test_timeout_restart();
        int base;
        base = load_seen;
        cur_hour = 5'd7;
        pulse_mode();
        wait_cyc(13);
        pulse_inc();
        wait_cyc(3);
        n_tests++; if (run_en !== 1'b0 || hour_data !== 5'd8) begin n_fail++; $display("FAIL no_abort_k17: run_en %b hour %0d want 0/8", run_en, hour_data); end
        wait_cyc(13);
        n_tests++; if (run_en !== 1'b0) begin n_fail++; $display("FAIL no_abort_k30: run_en %b want 0", run_en); end
        wait_cyc(1);
        n_tests++; if (run_en !== 1'b1) begin n_fail++; $display("FAIL abort_k31: run_en %b want 1", run_en); end
        n_tests++; if (load_seen !== base) begin n_fail++; $display("FAIL restart_no_load: got %0d loads want 0", load_seen - base); end
    endtask

    task automatic test_reset_mid_edit();
        int base;
        base = load_seen;
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        pulse_mode();
        pulse_mode();
        wait_cyc(1);
        n_tests++; if (edit_field !== 2'd2) begin n_fail++; $display("FAIL pre_reset_field: got %0d want 2", edit_field); end
        #2 clear = 1'b0;
        #1;
        n_tests++; if (run_en !== 1'b1 || edit_field !== 2'd0 || hour_data !== 5'd0 || hour_load !== 1'b0) begin n_fail++; $display("FAIL async_reset: run_en %b field %0d hour %0d load %b want 1/0/0/0", run_en, edit_field, hour_data, hour_load); end
        @(negedge clk);
        clear = 1'b1;
        wait_cyc(20);
        n_tests++; if (load_seen !== base || run_en !== 1'b1) begin n_fail++; $display("FAIL reset_no_load: loads %0d run_en %b want 0/1", load_seen - base, run_en); end
    endtask

    initial begin
        test_reset();
        test_full_set();
        test_wrap();
        test_out_of_range();
        test_simultaneous();
        test_timeout();
        test_timeout_restart();
        test_reset_mid_edit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
